// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode/state enums and the reference result model.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {IDLE, TRACK, FAIL} sb_state_t;

   localparam int unsigned REF_W = 32;

   // Callers zero-extend operands and truncate the result, so SHR stays logical at any width.
   function automatic logic [REF_W-1:0] alu_ref(input alu_op_t op,
                                                input logic [REF_W-1:0] a,
                                                input logic [REF_W-1:0] b);
      logic [REF_W-1:0] r;
      r = '0;
      unique case (op)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NOT: r = ~a;
         OP_SHL: r = a << 1;
         OP_SHR: r = a >> 1;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_sb_fifo.sv
// Circular buffer of expected results; push/pop are pre-qualified by the caller.
module alu_sb_fifo #(
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PW'(1);
         if (pop_i)  rd_q <= rd_q + PW'(1);
         unique case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/alu_scoreboard.sv
// In-order ALU result scoreboard: queues model results per command and
// compares them against returned results, tracking errors and pass/fail counts.
module alu_scoreboard
   import alu_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   input  logic [W-1:0]           OP1,
   input  logic [W-1:0]           OP2,
   input  logic [2:0]             OPCODE,
   input  logic                   res_valid,
   input  logic [W-1:0]           res,
   output logic                   cmd_ready,
   output logic [$clog2(DEPTH):0] pending,
   output logic                   mismatch,
   output logic [W-1:0]           exp_res,
   output logic                   err,
   output logic                   ovf_err,
   output logic                   unf_err,
   output logic [CNT_W-1:0]       pass_cnt,
   output logic [CNT_W-1:0]       fail_cnt
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic             empty, full, push, pop, ovf, unf, miss, err_set;
   logic [W-1:0]     ref_res, head;
   logic [CW-1:0]    pend_d;
   logic             cmd_ready_q, mismatch_q, err_q, ovf_q, unf_q;
   logic [W-1:0]     exp_res_q;
   logic [CNT_W-1:0] pass_q, fail_q;
   sb_state_t        state_q;

   assign ref_res = W'(alu_ref(alu_op_t'(OPCODE), REF_W'(OP1), REF_W'(OP2)));

   assign empty   = (pending == '0);
   assign full    = (pending == FULL_CNT);
   assign pop     = res_valid && !empty;
   // A pop in the same cycle frees the slot, so a full queue still accepts the push.
   assign push    = cmd_valid && (!full || pop);
   assign ovf     = cmd_valid && full && !pop;
   assign unf     = res_valid && empty;
   assign miss    = pop && (head != res);
   assign err_set = miss || ovf || unf;
   assign pend_d  = pending + CW'(push) - CW'(pop);

   alu_sb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (ref_res),
      .dout_o  (head),
      .count_o (pending)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready_q <= 1'b1;
         mismatch_q  <= 1'b0;
         exp_res_q   <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         pass_q      <= '0;
         fail_q      <= '0;
         state_q     <= IDLE;
      end else begin
         cmd_ready_q <= (pend_d != FULL_CNT);
         mismatch_q  <= miss;
         if (pop) begin
            exp_res_q <= head;
            if (miss) begin
               if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
            end else begin
               if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
            end
         end
         if (ovf)     ovf_q <= 1'b1;
         if (unf)     unf_q <= 1'b1;
         if (err_set) err_q <= 1'b1;
         unique case (state_q)
            IDLE:    if (err_set) state_q <= FAIL;
                     else if (push) state_q <= TRACK;
            TRACK:   if (err_set) state_q <= FAIL;
                     else if (pend_d == '0) state_q <= IDLE;
            FAIL:    state_q <= FAIL;
            default: state_q <= FAIL;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign mismatch  = mismatch_q;
   assign exp_res   = exp_res_q;
   assign err       = err_q;
   assign ovf_err   = ovf_q;
   assign unf_err   = unf_q;
   assign pass_cnt  = pass_q;
   assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_alu_scoreboard.sv
// Randomised scoreboard bench for alu_scoreboard against a queue-based reference model.
module tb_alu_scoreboard;
   import alu_pkg::*;

   localparam int W = 4, DEPTH = 4, CNT_W = 16;
   localparam int MOD = 1 << W;

   logic clk, rst, cmd_valid, res_valid;
   logic [W-1:0] OP1, OP2, res;
   logic [2:0] OPCODE;
   logic cmd_ready, mismatch, err, ovf_err, unf_err;
   logic [$clog2(DEPTH):0] pending;
   logic [W-1:0] exp_res;
   logic [CNT_W-1:0] pass_cnt, fail_cnt;

   alu_scoreboard #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .OP1(OP1), .OP2(OP2),
      .OPCODE(OPCODE), .res_valid(res_valid), .res(res), .cmd_ready(cmd_ready),
      .pending(pending), .mismatch(mismatch), .exp_res(exp_res), .err(err),
      .ovf_err(ovf_err), .unf_err(unf_err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int pending; int ready; int mis; int expv; int err;
      int ovf; int unf; int pass; int fail; sb_state_t st;
   } rec_t;

   rec_t sbq[$];
   int   mq[$];
   int   m_exp, m_pass, m_fail;
   bit   m_err, m_ovf, m_unf;
   int   tests = 0, fails = 0;

   task automatic chk(input string nm, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic int alu_model(input int op, input int a, input int b);
      case (op)
         0: return (a + b) % MOD;
         1: return (a - b + MOD) % MOD;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return MOD - 1 - a;
         6: return (a * 2) % MOD;
         default: return a / 2;
      endcase
   endfunction

   function automatic int head();
      return (mq.size() > 0) ? mq[0] : 0;
   endfunction

   function automatic int wrong();
      return (head() + 1 + int'($urandom_range(0, MOD - 2))) % MOD;
   endfunction

   function automatic sb_state_t m_state();
      if (m_err) return FAIL;
      return (mq.size() > 0) ? TRACK : IDLE;
   endfunction

   task automatic cyc(input bit cv, input int op, input int a, input int b,
                      input bit rv, input int r);
      int sz; bit pop, push, ovf, unf; int mis; int e; rec_t rec;
      @(negedge clk);
      cmd_valid = cv; OPCODE = 3'(op); OP1 = W'(a); OP2 = W'(b);
      res_valid = rv; res = W'(r);
      sz   = mq.size();
      pop  = rv && sz > 0;
      unf  = rv && sz == 0;
      push = cv && (sz < DEPTH || pop);
      ovf  = cv && sz == DEPTH && !pop;
      mis  = 0;
      if (pop) begin
         e = mq.pop_front();
         m_exp = e;
         if (e != r) begin mis = 1; m_fail++; end
         else m_pass++;
      end
      if (push) mq.push_back(alu_model(op, a, b));
      m_ovf |= ovf;
      m_unf |= unf;
      m_err |= ovf | unf | (mis != 0);
      rec = '{mq.size(), (mq.size() < DEPTH), mis, m_exp, m_err, m_ovf, m_unf,
              m_pass, m_fail, m_state()};
      sbq.push_back(rec);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic push_rand();
      cyc(1, $urandom_range(0, 7), $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 0, 0);
   endtask

   task automatic pair_rand();
      cyc(1, $urandom_range(0, 7), $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 1, head());
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_pending"},   int'(pending), 0);
      chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      chk({tag, "_mismatch"},  int'(mismatch), 0);
      chk({tag, "_exp_res"},   int'(exp_res), 0);
      chk({tag, "_err"},       int'(err), 0);
      chk({tag, "_ovf_err"},   int'(ovf_err), 0);
      chk({tag, "_unf_err"},   int'(unf_err), 0);
      chk({tag, "_pass_cnt"},  int'(pass_cnt), 0);
      chk({tag, "_fail_cnt"},  int'(fail_cnt), 0);
      chk({tag, "_state"},     int'(dut.state_q), int'(IDLE));
   endtask

   // Asserted between edges so the async path is observed without a clock.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      rst = 1'b1; cmd_valid = 1'b0; res_valid = 1'b0;
      #1;
      check_reset_state(tag);
      mq.delete();
      m_exp = 0; m_pass = 0; m_fail = 0; m_err = 0; m_ovf = 0; m_unf = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: one expected record per stimulated cycle, checked just after the edge.
   initial begin
      rec_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pending",   int'(pending),   e.pending);
            chk("cmd_ready", int'(cmd_ready), e.ready);
            chk("mismatch",  int'(mismatch),  e.mis);
            chk("exp_res",   int'(exp_res),   e.expv);
            chk("err",       int'(err),       e.err);
            chk("ovf_err",   int'(ovf_err),   e.ovf);
            chk("unf_err",   int'(unf_err),   e.unf);
            chk("pass_cnt",  int'(pass_cnt),  e.pass);
            chk("fail_cnt",  int'(fail_cnt),  e.fail);
            chk("state",     int'(dut.state_q), int'(e.st));
         end
      end
   end

   initial begin
      int cnt;
      rst = 1'b1; cmd_valid = 1'b0; res_valid = 1'b0;
      OP1 = '0; OP2 = '0; OPCODE = '0; res = '0;
      m_exp = 0; m_pass = 0; m_fail = 0; m_err = 0; m_ovf = 0; m_unf = 0;
      #1;
      check_reset_state("por");
      @(negedge clk);
      rst = 1'b0;

      // ADD 3+4 returns 7
      cyc(1, OP_ADD, 3, 4, 0, 0);
      cyc(0, 0, 0, 0, 1, 7);
      idle();
      // SUB 2-5 returns D, then SHL 9 returned wrongly as 3
      cyc(1, OP_SUB, 2, 5, 0, 0);
      cyc(0, 0, 0, 0, 1, 13);
      cyc(1, OP_SHL, 9, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 3);
      idle();

      async_reset("rst1");
      // Fill, overflow, drain
      repeat (DEPTH) push_rand();
      cyc(1, OP_ADD, 1, 1, 0, 0);
      repeat (DEPTH) cyc(0, 0, 0, 0, 1, head());
      // Underflow
      cyc(0, 0, 0, 0, 1, 5);
      idle();

      async_reset("rst2");
      // Full queue push+pop, then back-to-back pairs across pointer wrap
      repeat (DEPTH) push_rand();
      pair_rand();
      repeat (2 * DEPTH) pair_rand();
      repeat (DEPTH) cyc(0, 0, 0, 0, 1, head());
      idle();

      // Reset with 3 entries pending
      repeat (3) push_rand();
      idle();
      async_reset("rst3");

      // Random, always-correct results and no protocol violations
      repeat (200) begin
         bit rv, cv;
         rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
         cv = ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH || rv);
         cyc(cv, $urandom_range(0, 7), $urandom_range(0, MOD - 1),
             $urandom_range(0, MOD - 1), rv, head());
      end
      idle();
      async_reset("rst4");

      // Fully random, including wrong results, overflow and underflow
      repeat (300) begin
         bit rv, cv; int r;
         rv = ($urandom_range(0, 99) < 55);
         cv = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 20) ? wrong() : head();
         cyc(cv, $urandom_range(0, 7), $urandom_range(0, MOD - 1),
             $urandom_range(0, MOD - 1), rv, r);
      end
      idle();

      cnt = 0;
      while (sbq.size() > 0 && cnt < 10) begin
         @(posedge clk);
         cnt++;
      end
      #2;
      if (sbq.size() != 0) chk("monitor_drain_timeout", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_scoreboard.md
# alu_scoreboard

Self-checking result scoreboard for the `alu` block. It sits on the far side of the ALU: it captures every issued command (OP1, OP2, OPCODE) into a small in-order queue and computes the expected result with a built-in reference model. When the ALU presents a result, it compares it against the oldest pending expectation. It reports per-result mismatches, sticky error status, protocol violations and pass/fail counts for FPV cover traces and simulation benches.

## Interface
- `W`, 4: operand and result width.
- `DEPTH`, 4: pending-command queue depth. Must be a power of two, at least 2.
- `CNT_W`, 16: width of the pass and fail counters.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cmd_valid`, in, 1: a command is issued to the ALU this cycle.
- `OP1`, in, W: first operand of the issued command.
- `OP2`, in, W: second operand of the issued command.
- `OPCODE`, in, 3: operation of the issued command.
- `res_valid`, in, 1: the ALU presents a result this cycle.
- `res`, in, W: the ALU result.
- `cmd_ready`, out, 1: the queue is not full.
- `pending`, out, $clog2(DEPTH)+1: number of queued expectations.
- `mismatch`, out, 1: one-cycle pulse; the last compared result differed from its expectation.
- `exp_res`, out, W: expected value from the last compare, registered.
- `err`, out, 1: sticky; set by a mismatch, an overflow or an underflow.
- `ovf_err`, out, 1: sticky; a command arrived while the queue was full.
- `unf_err`, out, 1: sticky; a result arrived while the queue was empty.
- `pass_cnt`, out, CNT_W: count of matching results.
- `fail_cnt`, out, CNT_W: count of mismatching results.

## Operation
- Reference model, result truncated to W bits:
  - 000 ADD: OP1+OP2.
  - 001 SUB: OP1−OP2, two's-complement wrap.
  - 010 AND, 011 OR, 100 XOR.
  - 101 NOT OP1.
  - 110 SHL OP1 by 1.
  - 111 SHR OP1 by 1, logical.
- Push: when `cmd_valid` is high and the queue is not full, the model result is computed and stored at the tail. The queue holds expected values only.
- Pop/compare: when `res_valid` is high and the queue is not empty, the head is popped and compared with `res`. A match increments `pass_cnt`; a mismatch increments `fail_cnt`, pulses `mismatch` and sets `err`.
- Simultaneous push and pop:
  - When not empty: both occur; `pending` is unchanged.
  - When empty: the result is an underflow (`unf_err`). The command is still pushed. There is no bypass.
  - When full: the pop frees space, so the push is accepted.
- Push while full (and no pop): the command is dropped and `ovf_err` is set. The queue is unchanged.
- Pointers wrap modulo DEPTH. Full/empty are decided from `pending`.
- Counters saturate at all-ones.
- FSM, state register visible to the bench hierarchically:
  - IDLE: `pending` is 0.
  - TRACK: `pending` > 0.
  - FAIL: absorbing after `err` is set. Queue and counters keep operating; only `rst` leaves FAIL.
  - Transitions: IDLE to TRACK on an accepted push. TRACK to IDLE when the last entry pops with no push. Any state to FAIL when `err` sets.

## Timing
- `cmd_ready` and `pending` are registered and reflect the queue state after the previous edge.
- Compare latency is 1 cycle: `mismatch`, `exp_res` and the counters update at the edge following the `res_valid` cycle.
- An expectation pushed at edge N can be compared by a `res_valid` in cycle N+1 or later. Minimum ALU turnaround is one cycle.
- Reset values (asynchronous, on `rst` high):
  - Queue empty; `pending`=0; `cmd_ready`=1.
  - `mismatch`=0, `exp_res`=0.
  - `err`, `ovf_err`, `unf_err` all 0.
  - Both counters 0; FSM in IDLE.
- Reset mid-operation discards all pending entries. Results arriving after reset release with an empty queue flag `unf_err`.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum holding the 3-bit opcodes above.
  - `alu_ref(op, a, b)` function implementing the reference model, shared with ALU assertions.
  - `sb_state_t` enum {IDLE, TRACK, FAIL}.
- One sub-module, `alu_sb_fifo`: a synchronous W-bit, DEPTH-entry circular buffer with push, pop and count, reset to empty. It is instantiated once. The top level holds the model, compare logic, counters and FSM.

## Test plan
- Reset, then push ADD 3+4 and return `res`=7 one cycle later → `pass_cnt`=1, `mismatch`=0, state IDLE.
- Push SUB 2−5 and return `res`=4'hD → pass. Then push SHL 4'h9 and return 4'h3 → `mismatch` pulse, `exp_res`=4'h2, `fail_cnt`=1, `err`=1, state FAIL.
- Push 4 commands with no results → `pending`=4, `cmd_ready`=0. A 5th push → `ovf_err`=1 and `pending` stays 4. Then drain with 4 correct results → `pass_cnt`=4.
- Assert `res_valid` with the queue empty → `unf_err`=1, `err`=1, counters unchanged.
- With the queue full, push and pop in the same cycle → no overflow and `pending` stays 4. Run 2·DEPTH continuous back-to-back push/pop pairs (pointer wrap) → all pass.
- Assert `rst` asynchronously with 3 entries pending → immediately `pending`=0, flags and counters cleared, state IDLE.
